// File: rtl/pipe_flush_ctrl.sv
// Flush/redirect sequencer for the front end and pipeline registers.
// Collects redirect events (EX branch mispredict; WB exception, ertn, refetch,
// idle), issues one-cycle registered flush pulses per pipeline stage and a
// single redirect PC to fetch, and sequences refetch drain and idle wait.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   ex_br_*              EX mispredict event and correct target
//   wb_excp_*, wb_ertn_* WB exception entry / ertn return address
//   wb_refetch_*         WB refetch event and pc+4 of the instruction
//   wb_idle_*            WB idle event and pc of the idle instruction
//   intr_pending         wakes IDLE
//   dcache_busy          holds DRAIN until the store path is empty
//   flush_*              per-stage flush pulses
//   fifo_id_flush_cause  00 none, 01 branch, 10 exception/ertn, 11 refetch/idle
//   redirect_valid/pc    fetch restart pulse and held target
//   fetch_stall          fetch must not issue while draining or idle
module pipe_flush_ctrl #(
  parameter logic [31:0] PC_RESET  = 32'h1c000000,
  parameter int unsigned DRAIN_MAX = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_br_mispredict,
  input  logic [31:0] ex_br_target,
  input  logic        wb_excp_valid,
  input  logic [31:0] wb_excp_entry,
  input  logic        wb_ertn_valid,
  input  logic [31:0] wb_ertn_era,
  input  logic        wb_refetch_valid,
  input  logic [31:0] wb_refetch_pc,
  input  logic        wb_idle_valid,
  input  logic [31:0] wb_idle_pc,
  input  logic        intr_pending,
  input  logic        dcache_busy,
  output logic        flush_if,
  output logic        fifo_id_flush,
  output logic [1:0]  fifo_id_flush_cause,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        flush_mem_wb,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        fetch_stall
);

  // Counter is at least one bit wide so DRAIN_MAX = 0 (no limit) stays legal.
  localparam int unsigned CW = (DRAIN_MAX > 0) ? $clog2(DRAIN_MAX + 1) : 1;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_BRANCH = 2'b01;
  localparam logic [1:0] CAUSE_EXCP   = 2'b10;
  localparam logic [1:0] CAUSE_REFCH  = 2'b11;

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   saved_pc, saved_pc_nxt;
  logic [CW-1:0] drain_cnt, drain_cnt_nxt;
  logic          front_nxt, back_nxt, redir_nxt;
  logic [1:0]    cause_nxt;
  logic [31:0]   redir_pc_nxt;
  logic          drain_done;

  assign drain_done = !dcache_busy ||
                      ((DRAIN_MAX != 0) && (drain_cnt == CW'(DRAIN_MAX - 1)));

  // Next-state and next-output selection; exception overrides every state.
  always_comb begin
    state_nxt     = state;
    saved_pc_nxt  = saved_pc;
    drain_cnt_nxt = drain_cnt;
    front_nxt     = 1'b0;
    back_nxt      = 1'b0;
    redir_nxt     = 1'b0;
    cause_nxt     = CAUSE_NONE;
    redir_pc_nxt  = redirect_pc;
    if (wb_excp_valid) begin
      front_nxt     = 1'b1;
      back_nxt      = 1'b1;
      cause_nxt     = CAUSE_EXCP;
      redir_nxt     = 1'b1;
      redir_pc_nxt  = wb_excp_entry;
      state_nxt     = RUN;
      drain_cnt_nxt = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (wb_ertn_valid) begin
            front_nxt    = 1'b1;
            back_nxt     = 1'b1;
            cause_nxt    = CAUSE_EXCP;
            redir_nxt    = 1'b1;
            redir_pc_nxt = wb_ertn_era;
          end else if (wb_refetch_valid) begin
            front_nxt     = 1'b1;
            back_nxt      = 1'b1;
            cause_nxt     = CAUSE_REFCH;
            saved_pc_nxt  = wb_refetch_pc;
            drain_cnt_nxt = '0;
            state_nxt     = DRAIN;
          end else if (wb_idle_valid) begin
            front_nxt    = 1'b1;
            back_nxt     = 1'b1;
            cause_nxt    = CAUSE_REFCH;
            saved_pc_nxt = wb_idle_pc + 32'd4;
            state_nxt    = IDLE;
          end else if (ex_br_mispredict) begin
            front_nxt    = 1'b1;
            cause_nxt    = CAUSE_BRANCH;
            redir_nxt    = 1'b1;
            redir_pc_nxt = ex_br_target;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            redir_nxt     = 1'b1;
            redir_pc_nxt  = saved_pc;
            drain_cnt_nxt = '0;
            state_nxt     = RUN;
          end else if (drain_cnt != '1) begin
            drain_cnt_nxt = drain_cnt + CW'(1);
          end
        end
        IDLE: begin
          if (intr_pending) begin
            redir_nxt    = 1'b1;
            redir_pc_nxt = saved_pc;
            state_nxt    = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state               <= RUN;
      saved_pc            <= '0;
      drain_cnt           <= '0;
      flush_if            <= 1'b0;
      fifo_id_flush       <= 1'b0;
      fifo_id_flush_cause <= CAUSE_NONE;
      flush_id_ex         <= 1'b0;
      flush_ex_mem        <= 1'b0;
      flush_mem_wb        <= 1'b0;
      redirect_valid      <= 1'b0;
      redirect_pc         <= PC_RESET;
      fetch_stall         <= 1'b0;
    end else begin
      state               <= state_nxt;
      saved_pc            <= saved_pc_nxt;
      drain_cnt           <= drain_cnt_nxt;
      flush_if            <= front_nxt;
      fifo_id_flush       <= front_nxt;
      fifo_id_flush_cause <= cause_nxt;
      flush_id_ex         <= front_nxt;
      flush_ex_mem        <= back_nxt;
      flush_mem_wb        <= back_nxt;
      redirect_valid      <= redir_nxt;
      redirect_pc         <= redir_pc_nxt;
      fetch_stall         <= (state_nxt != RUN);
    end
  end

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Self-checking bench for pipe_flush_ctrl: vector table, corner-case
// sequences, then randomized traffic against a behavioural model.
module tb_pipe_flush_ctrl;

  localparam logic [31:0] PC_RST = 32'h1c000000;
  localparam int unsigned DMAX   = 16;

  typedef struct packed {
    logic        br;   logic [31:0] br_t;
    logic        ex;   logic [31:0] ex_e;
    logic        er;   logic [31:0] era;
    logic        rf;   logic [31:0] rf_pc;
    logic        id;   logic [31:0] id_pc;
    logic        intr;
    logic        busy;
  } in_t;

  typedef struct packed {
    logic        f_if;
    logic        f_fid;
    logic [1:0]  cause;
    logic        f_idex;
    logic        f_exmem;
    logic        f_memwb;
    logic        rv;
    logic [31:0] rpc;
    logic        stall;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_br_mispredict, wb_excp_valid, wb_ertn_valid;
  logic        wb_refetch_valid, wb_idle_valid, intr_pending, dcache_busy;
  logic [31:0] ex_br_target, wb_excp_entry, wb_ertn_era, wb_refetch_pc, wb_idle_pc;
  logic        flush_if, fifo_id_flush, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic [1:0]  fifo_id_flush_cause;
  logic        redirect_valid, fetch_stall;
  logic [31:0] redirect_pc;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_flush_ctrl #(.PC_RESET(PC_RST), .DRAIN_MAX(DMAX)) dut (
    .clk(clk), .rstn(rstn),
    .ex_br_mispredict(ex_br_mispredict), .ex_br_target(ex_br_target),
    .wb_excp_valid(wb_excp_valid), .wb_excp_entry(wb_excp_entry),
    .wb_ertn_valid(wb_ertn_valid), .wb_ertn_era(wb_ertn_era),
    .wb_refetch_valid(wb_refetch_valid), .wb_refetch_pc(wb_refetch_pc),
    .wb_idle_valid(wb_idle_valid), .wb_idle_pc(wb_idle_pc),
    .intr_pending(intr_pending), .dcache_busy(dcache_busy),
    .flush_if(flush_if), .fifo_id_flush(fifo_id_flush),
    .fifo_id_flush_cause(fifo_id_flush_cause),
    .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_stall(fetch_stall)
  );

  // Expected-output builder: front = IF/FIFO/ID flushes, back = EX/MEM/WB flushes.
  function automatic out_t mk(logic front, logic back, logic [1:0] cause,
                              logic rv, logic [31:0] rpc, logic stall);
    out_t o;
    o.f_if = front; o.f_fid = front; o.f_idex = front;
    o.f_exmem = back; o.f_memwb = back;
    o.cause = cause; o.rv = rv; o.rpc = rpc; o.stall = stall;
    return o;
  endfunction

  function automatic in_t none_in();
    in_t i;
    i = '0;
    return i;
  endfunction

  task automatic drive(input in_t i);
    ex_br_mispredict = i.br;   ex_br_target  = i.br_t;
    wb_excp_valid    = i.ex;   wb_excp_entry = i.ex_e;
    wb_ertn_valid    = i.er;   wb_ertn_era   = i.era;
    wb_refetch_valid = i.rf;   wb_refetch_pc = i.rf_pc;
    wb_idle_valid    = i.id;   wb_idle_pc    = i.id_pc;
    intr_pending     = i.intr; dcache_busy   = i.busy;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = mk(1'b0, 1'b0, fifo_id_flush_cause, redirect_valid, redirect_pc, fetch_stall);
    act.f_if = flush_if; act.f_fid = fifo_id_flush; act.f_idex = flush_id_ex;
    act.f_exmem = flush_ex_mem; act.f_memwb = flush_mem_wb;
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got flush{if,fid,idex,exmem,memwb}=%b%b%b%b%b cause=%b rv=%b pc=%h stall=%b, want %b%b%b%b%b cause=%b rv=%b pc=%h stall=%b",
                  name, act.f_if, act.f_fid, act.f_idex, act.f_exmem, act.f_memwb,
                  act.cause, act.rv, act.rpc, act.stall,
                  exp.f_if, exp.f_fid, exp.f_idex, exp.f_exmem, exp.f_memwb,
                  exp.cause, exp.rv, exp.rpc, exp.stall);
  endtask

  // Apply inputs for one cycle, then check outputs 1 time unit after the edge.
  task automatic step(input string name, input in_t i, input out_t exp);
    drive(i);
    @(posedge clk); #1;
    check(name, exp);
  endtask

  // Behavioural reference: mode 0 running, 1 waiting for drain, 2 sleeping.
  int          m_mode;
  int          m_waited;
  logic [31:0] m_resume;
  logic [31:0] m_rpc;

  task automatic model(input in_t i, output out_t e);
    logic fr, bk, rv;
    logic [1:0] c;
    fr = 0; bk = 0; rv = 0; c = 2'b00;
    if (i.ex) begin
      fr = 1; bk = 1; c = 2'b10; rv = 1; m_rpc = i.ex_e; m_mode = 0; m_waited = 0;
    end else if (m_mode == 0) begin
      if (i.er) begin
        fr = 1; bk = 1; c = 2'b10; rv = 1; m_rpc = i.era;
      end else if (i.rf) begin
        fr = 1; bk = 1; c = 2'b11; m_resume = i.rf_pc; m_mode = 1; m_waited = 0;
      end else if (i.id) begin
        fr = 1; bk = 1; c = 2'b11; m_resume = 32'((64'(i.id_pc) + 64'd4) % 64'h1_0000_0000);
        m_mode = 2;
      end else if (i.br) begin
        fr = 1; c = 2'b01; rv = 1; m_rpc = i.br_t;
      end
    end else if (m_mode == 1) begin
      if (!i.busy || (DMAX != 0 && m_waited == int'(DMAX) - 1)) begin
        rv = 1; m_rpc = m_resume; m_mode = 0; m_waited = 0;
      end else m_waited++;
    end else begin
      if (i.intr) begin
        rv = 1; m_rpc = m_resume; m_mode = 0;
      end
    end
    e = mk(fr, bk, c, rv, m_rpc, m_mode != 0);
  endtask

  vec_t vt[9];

  initial begin
    in_t i;
    out_t e;

    // Single-cycle vectors starting from reset state.
    i = none_in();                                          vt[0] = '{i, mk(0,0,2'b00,0,PC_RST,0)};
    i = none_in(); i.br = 1; i.br_t = 32'h1c000100;         vt[1] = '{i, mk(1,0,2'b01,1,32'h1c000100,0)};
    i = none_in();                                          vt[2] = '{i, mk(0,0,2'b00,0,32'h1c000100,0)};
    i = none_in(); i.ex = 1; i.ex_e = 32'h1c008000; i.br = 1; i.br_t = 32'h1c000bad;
                                                            vt[3] = '{i, mk(1,1,2'b10,1,32'h1c008000,0)};
    i = none_in(); i.er = 1; i.era = 32'h1c000300;          vt[4] = '{i, mk(1,1,2'b10,1,32'h1c000300,0)};
    i = none_in(); i.br = 1; i.br_t = 32'h1c000400;         vt[5] = '{i, mk(1,0,2'b01,1,32'h1c000400,0)};
    i = none_in(); i.br = 1; i.br_t = 32'h1c000500;         vt[6] = '{i, mk(1,0,2'b01,1,32'h1c000500,0)};
    i = none_in(); i.er = 1; i.era = 32'h1c000600; i.rf = 1; i.rf_pc = 32'h1c000700;
    i.br = 1; i.br_t = 32'h1c000800;                        vt[7] = '{i, mk(1,1,2'b10,1,32'h1c000600,0)};
    i = none_in();                                          vt[8] = '{i, mk(0,0,2'b00,0,32'h1c000600,0)};

    drive(none_in());
    rstn = 1'b0;
    @(posedge clk); #1;
    check("reset", mk(0,0,2'b00,0,PC_RST,0));
    rstn = 1'b1;

    for (int k = 0; k < 9; k++) step($sformatf("vec%0d", k), vt[k].i, vt[k].o);

    // Refetch: drain held 5 cycles, then released by busy falling.
    i = none_in(); i.rf = 1; i.rf_pc = 32'h1c000040; i.busy = 1;
    step("refetch_pulse", i, mk(1,1,2'b11,0,32'h1c000600,1));
    i = none_in(); i.busy = 1;
    for (int k = 0; k < 5; k++) step("drain_hold", i, mk(0,0,2'b00,0,32'h1c000600,1));
    step("drain_release", none_in(), mk(0,0,2'b00,1,32'h1c000040,0));
    step("after_release", none_in(), mk(0,0,2'b00,0,32'h1c000040,0));

    // Refetch with busy stuck: forced redirect on the 16th drain cycle.
    i = none_in(); i.rf = 1; i.rf_pc = 32'h1c000080; i.busy = 1;
    step("refetch2_pulse", i, mk(1,1,2'b11,0,32'h1c000040,1));
    i = none_in(); i.busy = 1;
    for (int k = 1; k <= 16; k++)
      step($sformatf("drain_forced_%0d", k), i,
           (k == 16) ? mk(0,0,2'b00,1,32'h1c000080,0) : mk(0,0,2'b00,0,32'h1c000040,1));

    // Idle: stall for 20 cycles, wake on interrupt to idle_pc+4.
    i = none_in(); i.id = 1; i.id_pc = 32'h1c000200;
    step("idle_pulse", i, mk(1,1,2'b11,0,32'h1c000080,1));
    for (int k = 0; k < 20; k++) step("idle_hold", none_in(), mk(0,0,2'b00,0,32'h1c000080,1));
    i = none_in(); i.intr = 1;
    step("idle_wake", i, mk(0,0,2'b00,1,32'h1c000204,0));

    // Exception while idle.
    i = none_in(); i.id = 1; i.id_pc = 32'h1c000300;
    step("idle2_pulse", i, mk(1,1,2'b11,0,32'h1c000204,1));
    i = none_in(); i.ex = 1; i.ex_e = 32'h1c008000;
    step("idle_excp", i, mk(1,1,2'b10,1,32'h1c008000,0));

    // Branch while draining is ignored.
    i = none_in(); i.rf = 1; i.rf_pc = 32'h1c000044; i.busy = 1;
    step("refetch3_pulse", i, mk(1,1,2'b11,0,32'h1c008000,1));
    i = none_in(); i.br = 1; i.br_t = 32'h1c000999; i.busy = 1;
    step("drain_branch_ignored", i, mk(0,0,2'b00,0,32'h1c008000,1));
    step("drain3_release", none_in(), mk(0,0,2'b00,1,32'h1c000044,0));

    // Idle pc + 4 wraps to zero.
    i = none_in(); i.id = 1; i.id_pc = 32'hFFFFFFFC;
    step("wrap_pulse", i, mk(1,1,2'b11,0,32'h1c000044,1));
    i = none_in(); i.intr = 1;
    step("wrap_wake", i, mk(0,0,2'b00,1,32'h00000000,0));

    // Reset in the middle of a drain discards the latched pc.
    i = none_in(); i.rf = 1; i.rf_pc = 32'h1c000abc; i.busy = 1;
    step("refetch4_pulse", i, mk(1,1,2'b11,0,32'h0,1));
    i = none_in(); i.busy = 1;
    step("drain4_hold", i, mk(0,0,2'b00,0,32'h0,1));
    rstn = 1'b0;
    step("reset_mid_drain", none_in(), mk(0,0,2'b00,0,PC_RST,0));
    rstn = 1'b1;
    step("after_reset_no_pulse", none_in(), mk(0,0,2'b00,0,PC_RST,0));

    // Randomized traffic against the model.
    m_mode = 0; m_waited = 0; m_resume = '0; m_rpc = PC_RST;
    for (int k = 0; k < 3000; k++) begin
      i = none_in();
      i.br_t = $urandom; i.ex_e = $urandom; i.era = $urandom;
      i.rf_pc = $urandom; i.id_pc = $urandom;
      i.br   = ($urandom_range(0, 3) == 0);
      i.ex   = ($urandom_range(0, 19) == 0);
      i.intr = ($urandom_range(0, 9) == 0);
      i.busy = (k % 400 < 200) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 3) != 0);
      if (m_mode == 0) begin
        i.er = ($urandom_range(0, 11) == 0);
        i.rf = ($urandom_range(0, 11) == 0);
        i.id = ($urandom_range(0, 15) == 0);
      end
      model(i, e);
      step($sformatf("rand%0d", k), i, e);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
